// File: rtl/pll_ctrl_pkg.sv
// Shared types and sizing helpers for the PLL bring-up sequencer.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      PRST = 3'd0,
      WAIT = 3'd1,
      STAB = 3'd2,
      RUN  = 3'd3,
      FAIL = 3'd4
   } state_t;

   localparam int RETRY_W = 4;

   // One spare bit above the largest terminal count keeps the compare headroom simple.
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for signals arriving asynchronously to clk.
module sync_2ff #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_r;

   // First stage may go metastable; second stage hands a settled value to the fabric.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_r <= {W{1'b0}};
         q      <= {W{1'b0}};
      end else begin
         meta_r <= d;
         q      <= meta_r;
      end
   end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL bring-up sequencer on the crystal clock: PLL reset pulse, lock wait, debounce, supervision.
// Optional lock-loss counter output enabled by defining PLL_LOCK_LOSS_CNT_EN.
module pll_lock_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int RST_CYCLES   = 24,
   parameter int LOCK_TIMEOUT = 240000,
   parameter int LOCK_STABLE  = 2400,
   parameter int MAX_RETRY    = 3
) (
   input  logic               clkin,
   input  logic               reset,
   input  logic               pll_lock,
   input  logic               relock_req,
   output logic               pll_reset,
   output logic               rst_out,
   output logic               locked,
   output logic               fail,
   output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
   ,
   output logic [7:0]         loss_cnt
`endif
);

   localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);

   localparam logic [CW-1:0]      CNT_ZERO  = {CW{1'b0}};
   localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
   localparam logic [CW-1:0]      RST_LAST  = CW'(RST_CYCLES - 1);
   localparam logic [CW-1:0]      TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0]      STB_LAST  = CW'(LOCK_STABLE - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   state_t             state_r;
   logic [CW-1:0]      cnt_r;
   logic               lk_s;
   logic [RETRY_W-1:0] retry_nxt_s;

   sync_2ff #(.W(1)) u_lock_sync (
      .clk   (clkin),
      .reset (reset),
      .d     (pll_lock),
      .q     (lk_s)
   );

   // Retry count a timeout in WAIT would commit.
   always_comb begin
      retry_nxt_s = retry_cnt + 4'd1;
   end

   // Sequencer: state, shared cycle counter and all registered outputs move together.
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state_r   <= PRST;
         cnt_r     <= CNT_ZERO;
         pll_reset <= 1'b1;
         rst_out   <= 1'b1;
         locked    <= 1'b0;
         fail      <= 1'b0;
         retry_cnt <= 4'd0;
      end else begin
         case (state_r)
            PRST: begin
               rst_out <= 1'b1;
               locked  <= 1'b0;
               if (cnt_r == RST_LAST) begin
                  state_r   <= WAIT;
                  cnt_r     <= CNT_ZERO;
                  pll_reset <= 1'b0;
               end else begin
                  cnt_r     <= cnt_r + CNT_ONE;
                  pll_reset <= 1'b1;
               end
            end
            // A lock arriving on the timeout cycle takes priority over the retry.
            WAIT: begin
               if (lk_s) begin
                  state_r <= STAB;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == TMO_LAST) begin
                  retry_cnt <= retry_nxt_s;
                  cnt_r     <= CNT_ZERO;
                  pll_reset <= 1'b1;
                  if (retry_nxt_s == RETRY_MAX) begin
                     state_r <= FAIL;
                     fail    <= 1'b1;
                  end else begin
                     state_r <= PRST;
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            STAB: begin
               if (!lk_s) begin
                  state_r <= WAIT;
                  cnt_r   <= CNT_ZERO;
               end else if (cnt_r == STB_LAST) begin
                  state_r   <= RUN;
                  cnt_r     <= CNT_ZERO;
                  locked    <= 1'b1;
                  rst_out   <= 1'b0;
                  retry_cnt <= 4'd0;
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            RUN: begin
               if (!lk_s || relock_req) begin
                  state_r   <= PRST;
                  cnt_r     <= CNT_ZERO;
                  pll_reset <= 1'b1;
                  rst_out   <= 1'b1;
                  locked    <= 1'b0;
               end else begin
                  cnt_r <= CNT_ZERO;
               end
            end
            FAIL: begin
               if (relock_req) begin
                  state_r   <= PRST;
                  cnt_r     <= CNT_ZERO;
                  fail      <= 1'b0;
                  retry_cnt <= 4'd0;
               end else begin
                  cnt_r <= CNT_ZERO;
               end
            end
            default: begin
               state_r   <= PRST;
               cnt_r     <= CNT_ZERO;
               pll_reset <= 1'b1;
               rst_out   <= 1'b1;
               locked    <= 1'b0;
               fail      <= 1'b0;
               retry_cnt <= 4'd0;
            end
         endcase
      end
   end

`ifdef PLL_LOCK_LOSS_CNT_EN
   // Counts only lock drops seen in RUN; requested relocks are deliberate and excluded.
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         loss_cnt <= 8'd0;
      end else if ((state_r == RUN) && !lk_s && (loss_cnt != 8'hFF)) begin
         loss_cnt <= loss_cnt + 8'd1;
      end else begin
         loss_cnt <= loss_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Scoreboard bench: stimulus queues timed output-vector changes, a negedge monitor matches them.
module tb_pll_lock_ctrl;

   logic       clkin = 1'b0;
   logic       reset = 1'b1;
   logic       pll_lock = 1'b0;
   logic       relock_req = 1'b0;
   logic       pll_reset, rst_out, locked, fail;
   logic [3:0] retry_cnt;
`ifdef PLL_LOCK_LOSS_CNT_EN
   logic [7:0] loss_cnt;
`endif

   pll_lock_ctrl #(
      .RST_CYCLES(4), .LOCK_TIMEOUT(20), .LOCK_STABLE(8), .MAX_RETRY(3)
   ) dut (
`ifdef PLL_LOCK_LOSS_CNT_EN
      .loss_cnt   (loss_cnt),
`endif
      .clkin      (clkin),
      .reset      (reset),
      .pll_lock   (pll_lock),
      .relock_req (relock_req),
      .pll_reset  (pll_reset),
      .rst_out    (rst_out),
      .locked     (locked),
      .fail       (fail),
      .retry_cnt  (retry_cnt)
   );

   always #5 clkin = ~clkin;

   // Output vector: {pll_reset, rst_out, locked, fail, retry_cnt}
   localparam logic [7:0] V_RST  = 8'hC0;
   localparam logic [7:0] V_WAIT = 8'h40;
   localparam logic [7:0] V_RUN  = 8'h20;

   typedef struct {
      int         cyc;
      logic [7:0] val;
   } exp_t;

   exp_t       q[$];
   exp_t       e;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_err = 0;
   int         base;
   int         t;
   logic [7:0] cur;
   logic [7:0] prev = 8'hC0;

   always @(posedge clkin) cyc <= cyc + 1;

   always @(negedge clkin) begin
      cur = {pll_reset, rst_out, locked, fail, retry_cnt};
      if (cur !== prev) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_change cyc=%0d got=%h", cyc, cur);
         end else begin
            e = q.pop_front();
            if (cur !== e.val || cyc != e.cyc) begin
               n_err++;
               $display("FAIL out_event got=%h@%0d exp=%h@%0d", cur, cyc, e.val, e.cyc);
            end
         end
         prev = cur;
      end
   end

   task automatic push(input int c, input logic [7:0] v);
      exp_t x;
      x.cyc = c;
      x.val = v;
      q.push_back(x);
   endtask

   task automatic go_to(input int target);
      while (cyc < target) @(negedge clkin);
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic check_empty(input string name);
      n_cmp++;
      if (q.size() != 0) begin
         n_err++;
         $display("FAIL %s pending_events got=%0d exp=0", name, q.size());
      end
      q.delete();
   endtask

   task automatic do_reset(input bit expect_change);
      @(posedge clkin);
      #2;
      reset = 1'b1;
      if (expect_change) push(cyc, V_RST);
      repeat (2) @(negedge clkin);
   endtask

   task automatic release_reset();
      reset = 1'b0;
      base  = cyc;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      repeat (3) @(negedge clkin);
      chk("rst_pll_reset", {7'd0, pll_reset}, 8'd1);
      chk("rst_rst_out",   {7'd0, rst_out},   8'd1);
      chk("rst_locked",    {7'd0, locked},    8'd0);
      chk("rst_fail",      {7'd0, fail},      8'd0);
      chk("rst_retry",     {4'd0, retry_cnt}, 8'd0);

      // Clean bring-up: lock edge after e5 -> sync 2 + entry 1 + debounce 8 -> RUN at e16
      release_reset();
      push(base + 4,  V_WAIT);
      push(base + 16, V_RUN);
      go_to(base + 5);  pll_lock = 1'b1;
      go_to(base + 22);
      check_empty("bringup");

      // Single-cycle lock drop in RUN
      t = cyc;
      pll_lock = 1'b0;
      push(t + 3,  V_RST);
      push(t + 7,  V_WAIT);
      push(t + 16, V_RUN);
      go_to(t + 1);  pll_lock = 1'b1;
      go_to(t + 20);
      check_empty("lock_loss");
`ifdef PLL_LOCK_LOSS_CNT_EN
      chk("loss_cnt_after_drop", loss_cnt, 8'd1);
`endif

      // Requested relock from RUN
      t = cyc;
      relock_req = 1'b1;
      push(t + 1,  V_RST);
      push(t + 5,  V_WAIT);
      push(t + 14, V_RUN);
      go_to(t + 1);  relock_req = 1'b0;
      go_to(t + 18);
      check_empty("relock_run");
`ifdef PLL_LOCK_LOSS_CNT_EN
      chk("loss_cnt_after_relock", loss_cnt, 8'd1);
`endif

      // Debounce: 5-cycle glitch, 3 low, then steady
      pll_lock = 1'b0;
      do_reset(1'b1);
      release_reset();
      push(base + 4,  V_WAIT);
      push(base + 24, V_RUN);
      go_to(base + 5);  pll_lock = 1'b1;
      go_to(base + 10); pll_lock = 1'b0;
      go_to(base + 13); pll_lock = 1'b1;
      go_to(base + 28);
      check_empty("debounce");

      // Lock never arrives: three timeouts then give up
      pll_lock = 1'b0;
      do_reset(1'b1);
      release_reset();
      push(base + 4,  V_WAIT);
      push(base + 24, 8'hC1);
      push(base + 28, 8'h41);
      push(base + 48, 8'hC2);
      push(base + 52, 8'h42);
      push(base + 72, 8'hD3);
      go_to(base + 90);
      check_empty("timeouts");
      chk("fail_flag",      {7'd0, fail},      8'd1);
      chk("fail_pll_reset", {7'd0, pll_reset}, 8'd1);
      chk("fail_retry",     {4'd0, retry_cnt}, 8'd3);

      // Relock out of the give-up state, then reach STAB and ignore a relock there
      t = cyc;
      relock_req = 1'b1;
      push(t + 1, V_RST);
      push(t + 5, V_WAIT);
      go_to(t + 1);  relock_req = 1'b0;
      chk("relock_fail_clr",  {7'd0, fail},      8'd0);
      chk("relock_retry_clr", {4'd0, retry_cnt}, 8'd0);
      go_to(t + 5);  pll_lock = 1'b1;
      go_to(t + 9);  relock_req = 1'b1;
      go_to(t + 10); relock_req = 1'b0;

      // Asynchronous reset while debouncing
      @(posedge clkin);
      #2;
      reset = 1'b1;
      push(cyc, V_RST);
      #1;
      chk("async_pll_reset", {7'd0, pll_reset}, 8'd1);
      chk("async_rst_out",   {7'd0, rst_out},   8'd1);
      chk("async_locked",    {7'd0, locked},    8'd0);
      chk("async_fail",      {7'd0, fail},      8'd0);
      chk("async_retry",     {4'd0, retry_cnt}, 8'd0);
`ifdef PLL_LOCK_LOSS_CNT_EN
      chk("async_loss_cnt", loss_cnt, 8'd0);
`endif
      repeat (3) @(negedge clkin);
      check_empty("async_reset");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
